pair_triple_stream_detector: RTL and testbench



---
 rtl/pair_triple_stream_detector.sv | 110 +++++++++++
 tb/tb_pair_triple_stream_detector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_triple_stream_detector.sv
// Streaming popcount qualifier: counts set bits per sample, tracks a saturating run of
// qualifying samples and returns detect/count/run through a one-entry output buffer.
module pair_triple_stream_detector #(
    parameter int NBITS  = 3,
    parameter int THRESH = 2,
    parameter int MODE   = 0,
    parameter int HOLD   = 1,
    localparam int CW    = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_detect,
    output logic [CW-1:0]    out_count,
    output logic [7:0]       out_run
);

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [7:0]    HOLD_C   = 8'(HOLD);

    logic          out_val_q, out_val_d;
    logic          out_detect_q, out_detect_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic [7:0]    out_run_q, out_run_d;
    logic [7:0]    run_q, run_d;

    logic          accept;
    logic [CW-1:0] pop;
    logic          qual;
    logic [7:0]    run_next;
    logic          detect;

    // Ready allows the buffer to drain and refill on the same edge.
    assign in_rdy = rst_n && !clear && (!out_val_q || out_rdy);
    assign accept = in_val && in_rdy;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NBITS; i++) begin
            pop = pop + {{(CW-1){1'b0}}, in_data[i]};
        end
    end

    always_comb begin
        if (MODE == 0) begin
            qual = (pop >= THRESH_C);
        end else begin
            qual = (pop == THRESH_C);
        end
        // Run length saturates at 255 so long streams keep detecting.
        if (!qual) begin
            run_next = 8'd0;
        end else if (run_q == 8'hFF) begin
            run_next = 8'hFF;
        end else begin
            run_next = run_q + 8'd1;
        end
        detect = qual && (run_next >= HOLD_C);
    end

    always_comb begin
        out_val_d    = out_val_q;
        out_detect_d = out_detect_q;
        out_count_d  = out_count_q;
        out_run_d    = out_run_q;
        run_d        = run_q;
        if (clear) begin
            out_val_d    = 1'b0;
            out_detect_d = 1'b0;
            out_count_d  = '0;
            out_run_d    = 8'd0;
            run_d        = 8'd0;
        end else if (accept) begin
            out_val_d    = 1'b1;
            out_detect_d = detect;
            out_count_d  = pop;
            out_run_d    = run_next;
            run_d        = run_next;
        end else if (out_val_q && out_rdy) begin
            out_val_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_q    <= 1'b0;
            out_detect_q <= 1'b0;
            out_count_q  <= '0;
            out_run_q    <= 8'd0;
            run_q        <= 8'd0;
        end else begin
            out_val_q    <= out_val_d;
            out_detect_q <= out_detect_d;
            out_count_q  <= out_count_d;
            out_run_q    <= out_run_d;
            run_q        <= run_d;
        end
    end

    assign out_val    = out_val_q;
    assign out_detect = out_detect_q;
    assign out_count  = out_count_q;
    assign out_run    = out_run_q;

endmodule

// File: tb/tb_pair_triple_stream_detector.sv
// Scoreboard bench for pair_triple_stream_detector across four parameter sets.
module tb_pair_triple_stream_detector;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_val;
    logic [3:0] in_data;
    logic       out_rdy;
    logic [1:0] sel;

    logic       iv   [4];
    logic       ir   [4];
    logic       ov   [4];
    logic       od   [4];
    logic [7:0] orun [4];
    logic [1:0] oc0, oc1, oc3;
    logic [2:0] oc2;

    logic       mon_val, mon_rdy, mon_det;
    logic [2:0] mon_cnt;
    logic [7:0] mon_run;

    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    assign iv[0] = in_val && (sel == 2'd0);
    assign iv[1] = in_val && (sel == 2'd1);
    assign iv[2] = in_val && (sel == 2'd2);
    assign iv[3] = in_val && (sel == 2'd3);

    pair_triple_stream_detector #(.NBITS(3), .THRESH(2), .MODE(0), .HOLD(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(iv[0]), .in_rdy(ir[0]),
        .in_data(in_data[2:0]), .out_val(ov[0]), .out_rdy(out_rdy),
        .out_detect(od[0]), .out_count(oc0), .out_run(orun[0]));

    pair_triple_stream_detector #(.NBITS(3), .THRESH(2), .MODE(0), .HOLD(3)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(iv[1]), .in_rdy(ir[1]),
        .in_data(in_data[2:0]), .out_val(ov[1]), .out_rdy(out_rdy),
        .out_detect(od[1]), .out_count(oc1), .out_run(orun[1]));

    pair_triple_stream_detector #(.NBITS(4), .THRESH(2), .MODE(1), .HOLD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(iv[2]), .in_rdy(ir[2]),
        .in_data(in_data), .out_val(ov[2]), .out_rdy(out_rdy),
        .out_detect(od[2]), .out_count(oc2), .out_run(orun[2]));

    pair_triple_stream_detector #(.NBITS(3), .THRESH(2), .MODE(0), .HOLD(2)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(iv[3]), .in_rdy(ir[3]),
        .in_data(in_data[2:0]), .out_val(ov[3]), .out_rdy(out_rdy),
        .out_detect(od[3]), .out_count(oc3), .out_run(orun[3]));

    always_comb begin
        mon_val = ov[sel];
        mon_rdy = ir[sel];
        mon_det = od[sel];
        mon_run = orun[sel];
        case (sel)
            2'd0:    mon_cnt = {1'b0, oc0};
            2'd1:    mon_cnt = {1'b0, oc1};
            2'd2:    mon_cnt = oc2;
            default: mon_cnt = {1'b0, oc3};
        endcase
    end

    function automatic logic [11:0] pk(input logic d, input logic [2:0] c, input logic [7:0] r);
        return {d, c, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // scoreboard monitor: compares each result on the cycle it is consumed
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n && mon_val && out_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result sel=%0d got det=%0d cnt=%0d run=%0d",
                         sel, mon_det, mon_cnt, mon_run);
            end else begin
                e = exp_q.pop_front();
                if ({mon_det, mon_cnt, mon_run} !== e) begin
                    errors++;
                    $display("FAIL result sel=%0d got det=%0d cnt=%0d run=%0d want det=%0d cnt=%0d run=%0d",
                             sel, mon_det, mon_cnt, mon_run, e[11], e[10:8], e[7:0]);
                end
            end
        end
    end

    // driver: holds the sample until it is accepted, then records its expected result
    task automatic send(input logic [3:0] d, input logic [11:0] e);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        in_val = 1'b1;
        in_data = d;
        while (!done && n < 50) begin
            @(negedge clk);
            if (mon_rdy) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_val = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%0d got not_accepted want accepted", d);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_val) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        in_val = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        sel = 2'd0;
        #1;
        chk("reset_out_val", mon_val, 0);
        chk("reset_out_detect", mon_det, 0);
        chk("reset_out_count", mon_cnt, 0);
        chk("reset_out_run", mon_run, 0);
        chk("reset_in_rdy", mon_rdy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rdy_after_reset", mon_rdy, 1);
        out_rdy = 1'b1;

        // defaults: pair/triple detection, one per cycle
        send(4'b0011, pk(1, 3'd2, 8'd1));
        chk("latency_out_val", mon_val, 1);
        send(4'b0100, pk(0, 3'd1, 8'd0));
        send(4'b0111, pk(1, 3'd3, 8'd1));
        send(4'b0000, pk(0, 3'd0, 8'd0));
        wait_drain();

        // HOLD=3
        sel = 2'd1;
        send(4'b0011, pk(0, 3'd2, 8'd1));
        send(4'b0110, pk(0, 3'd2, 8'd2));
        send(4'b0101, pk(1, 3'd2, 8'd3));
        send(4'b0001, pk(0, 3'd1, 8'd0));
        send(4'b0111, pk(0, 3'd3, 8'd1));
        wait_drain();

        // MODE=1 exact match, NBITS=4
        sel = 2'd2;
        send(4'b0011, pk(1, 3'd2, 8'd1));
        send(4'b0111, pk(0, 3'd3, 8'd0));
        send(4'b1111, pk(0, 3'd4, 8'd0));
        wait_drain();

        // backpressure: two samples offered while the consumer stalls
        sel = 2'd0;
        out_rdy = 1'b0;
        fork
            begin
                send(4'b0101, pk(1, 3'd2, 8'd1));
                send(4'b0110, pk(1, 3'd2, 8'd2));
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!mon_val && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 5; k++) begin
                    chk("stall_out_val", mon_val, 1);
                    chk("stall_in_rdy", mon_rdy, 0);
                    chk("stall_fields", {mon_det, mon_cnt, mon_run}, pk(1, 3'd2, 8'd1));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_drain();

        // saturation of the run counter
        send(4'b0000, pk(0, 3'd0, 8'd0));
        for (int i = 0; i < 300; i++) begin
            send(4'b0111, pk(1, 3'd3, (i >= 254) ? 8'd255 : 8'(i + 1)));
        end
        send(4'b0001, pk(0, 3'd1, 8'd0));
        wait_drain();

        // asynchronous reset with a result pending
        out_rdy = 1'b0;
        send(4'b0011, pk(1, 3'd2, 8'd1));
        chk("pre_reset_out_val", mon_val, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_val", mon_val, 0);
        chk("async_rst_out_detect", mon_det, 0);
        chk("async_rst_out_count", mon_cnt, 0);
        chk("async_rst_out_run", mon_run, 0);
        chk("async_rst_in_rdy", mon_rdy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // clear flushes a pending result and the run history (HOLD=2)
        sel = 2'd3;
        send(4'b0011, pk(0, 3'd2, 8'd1));
        clear = 1'b1;
        in_val = 1'b1;
        in_data = 4'b0111;
        @(negedge clk);
        chk("clear_in_rdy", mon_rdy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_val = 1'b0;
        chk("clear_out_val", mon_val, 0);
        chk("clear_out_run", mon_run, 0);
        chk("clear_out_count", mon_cnt, 0);
        out_rdy = 1'b1;
        send(4'b0011, pk(0, 3'd2, 8'd1));
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
